// File: rtl/hd_clkseq_pkg.sv
// rtl/hd_clkseq_pkg.sv - shared types, widths and legality check for the clock-gate sequencer
package hd_clkseq_pkg;

   // ST_ prefix keeps the state names clear of the SETTLE/STAGGER parameters
   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_GAP} state_t;

   function automatic int cnt_w(input int stagger);
      return $clog2(stagger + 1);
   endfunction

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic bit params_ok(input int n, input int stagger, input int settle);
      return (n >= 1) && (n <= 16) && (settle >= 1) && (stagger >= settle);
   endfunction

endpackage

// File: rtl/hd_rr_pick.sv
// rtl/hd_rr_pick.sv - combinational cyclic first-set picker starting at ptr
module hd_rr_pick #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  vec,
   input  logic [PW-1:0] ptr,
   output logic [PW-1:0] idx,
   output logic          valid
);

   logic [PW-1:0] hi_idx, lo_idx;
   logic          hi_vld, lo_vld;

   // Descending scan: the last hit is the lowest index, both overall and at/after ptr
   always_comb begin
      hi_idx = '0;
      lo_idx = '0;
      hi_vld = 1'b0;
      lo_vld = 1'b0;
      for (int j = N - 1; j >= 0; j--) begin
         if (vec[j]) begin
            lo_idx = PW'(j);
            lo_vld = 1'b1;
            if (j >= int'(ptr)) begin
               hi_idx = PW'(j);
               hi_vld = 1'b1;
            end
         end
      end
      valid = lo_vld;
      idx   = hi_vld ? hi_idx : lo_idx;
   end

endmodule

// File: rtl/hd_clkgate_seq.sv
// rtl/hd_clkgate_seq.sv - staggered round-robin clock-gate enable sequencer
module hd_clkgate_seq
   import hd_clkseq_pkg::*;
#(
   parameter int N       = 4,
   parameter int STAGGER = 8,
   parameter int SETTLE  = 2
) (
   input  logic         CK,
   input  logic         RST,
   input  logic [N-1:0] REQ,
   output logic [N-1:0] EN,
   output logic [N-1:0] ACK,
   output logic         BUSY
);

   localparam int CW = cnt_w(STAGGER);
   localparam int PW = idx_w(N);

   if (!params_ok(N, STAGGER, SETTLE)) begin : g_param_check
      $error("hd_clkgate_seq: illegal N/STAGGER/SETTLE combination");
   end

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [PW-1:0] ptr, ptr_nx, cur, cur_nx, pick_idx;
   logic [N-1:0]  en_nx, ack_nx, pend;
   logic          pick_vld, done;

   assign pend = REQ ^ EN;
   assign BUSY = (state != ST_IDLE);

   hd_rr_pick #(.N(N), .PW(PW)) u_pick (
      .vec   (pend),
      .ptr   (ptr),
      .idx   (pick_idx),
      .valid (pick_vld)
   );

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      ptr_nx   = ptr;
      cur_nx   = cur;
      en_nx    = EN;
      ack_nx   = ACK;
      done     = 1'b0;
      case (state)
         ST_IDLE: done = 1'b1;
         ST_SETTLE: begin
            if (cnt == CW'(SETTLE)) begin
               ack_nx[cur] = EN[cur];
               if (STAGGER > SETTLE) begin
                  state_nx = ST_GAP;
                  cnt_nx   = cnt + 1'b1;
               end else begin
                  done = 1'b1;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt == CW'(STAGGER)) done = 1'b1;
            else                     cnt_nx = cnt + 1'b1;
         end
         default: done = 1'b1;
      endcase
      // The edge that ends a window may itself grant, so back-to-back grants sit exactly STAGGER apart
      if (done) begin
         state_nx = ST_IDLE;
         cnt_nx   = '0;
         if (pick_vld) begin
            en_nx[pick_idx] = ~EN[pick_idx];
            cur_nx          = pick_idx;
            cnt_nx          = CW'(1);
            ptr_nx          = (pick_idx == PW'(N - 1)) ? '0 : pick_idx + 1'b1;
            state_nx        = ST_SETTLE;
         end
      end
   end

   always_ff @(posedge CK) begin
      if (RST) begin
         state <= ST_IDLE;
         cnt   <= '0;
         ptr   <= '0;
         cur   <= '0;
         EN    <= '0;
         ACK   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         ptr   <= ptr_nx;
         cur   <= cur_nx;
         EN    <= en_nx;
         ACK   <= ack_nx;
      end
   end

endmodule

// File: tb/tb_hd_clkgate_seq.sv
// tb/tb_hd_clkgate_seq.sv - scoreboard bench with time-based reference model for hd_clkgate_seq
module tb_hd_clkgate_seq;

   localparam int N       = 4;
   localparam int STAGGER = 8;
   localparam int SETTLE  = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req = '1;
   logic [N-1:0] EN, ACK;
   logic         BUSY;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [2*N:0] exp_q[$];

   int rise_t[N], fall_t[N], arise_t[N], afall_t[N];
   int bfall_t = -1;

   hd_clkgate_seq #(.N(N), .STAGGER(STAGGER), .SETTLE(SETTLE)) dut (
      .CK   (clk),
      .RST  (rst),
      .REQ  (req),
      .EN   (EN),
      .ACK  (ACK),
      .BUSY (BUSY)
   );

   always #5 clk = ~clk;

   // Reference model: grants allowed once STAGGER cycles have elapsed since the last one,
   // acknowledge scheduled SETTLE cycles after each grant
   initial begin
      logic [N-1:0] m_en, m_ack, pend;
      logic         m_busy;
      int           m_ptr, last_g, j;
      bit           any_g, picked;
      int           ack_t[$], ack_i[$];
      logic         ack_v[$];
      m_en = '0; m_ack = '0; m_ptr = 0; last_g = 0; any_g = 0;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            m_en = '0; m_ack = '0; m_ptr = 0; any_g = 0;
            ack_t.delete(); ack_i.delete(); ack_v.delete();
         end else begin
            while (ack_t.size() > 0 && ack_t[0] == cyc) begin
               m_ack[ack_i[0]] = ack_v[0];
               void'(ack_t.pop_front()); void'(ack_i.pop_front()); void'(ack_v.pop_front());
            end
            pend = req ^ m_en;
            if ((!any_g || (cyc - last_g) >= STAGGER) && pend != '0) begin
               picked = 0;
               for (int k = 0; k < N; k++) begin
                  j = (m_ptr + k) % N;
                  if (!picked && pend[j]) begin
                     picked = 1;
                     m_en[j] = ~m_en[j];
                     ack_t.push_back(cyc + SETTLE); ack_i.push_back(j); ack_v.push_back(m_en[j]);
                     last_g = cyc; any_g = 1; m_ptr = (j + 1) % N;
                  end
               end
            end
         end
         m_busy = !rst && any_g && ((cyc - last_g) < STAGGER);
         exp_q.push_back({m_en, m_ack, m_busy});
      end
   end

   // Monitor: pops one expectation per cycle and records edge times for directed checks
   initial begin
      logic [2*N:0] e;
      logic [N-1:0] p_en = '0, p_ack = '0;
      logic         p_busy = 1'b0;
      for (int i = 0; i < N; i++) begin
         rise_t[i] = -1; fall_t[i] = -1; arise_t[i] = -1; afall_t[i] = -1;
      end
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({EN, ACK, BUSY} !== e) begin
               failures++;
               $display("FAIL outputs edge=%0d en/ack/busy got %b/%b/%b want %b/%b/%b",
                        cyc, EN, ACK, BUSY, e[2*N:N+1], e[N:1], e[0]);
            end
            for (int i = 0; i < N; i++) begin
               if (!p_en[i] && EN[i])   rise_t[i]  = cyc;
               if (p_en[i] && !EN[i])   fall_t[i]  = cyc;
               if (!p_ack[i] && ACK[i]) arise_t[i] = cyc;
               if (p_ack[i] && !ACK[i]) afall_t[i] = cyc;
            end
            if (p_busy && !BUSY) bfall_t = cyc;
            p_en = EN; p_ack = ACK; p_busy = BUSY;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s got %0d want %0d", name, act, want);
      end
   endtask

   initial begin
      int t;
      // Reset held with all requests high, then all-on burst from reset release
      step(2);
      t = cyc;
      rst = 1'b0;
      step(40);
      chk("reset_release_en0", rise_t[0], t + 1);
      chk("reset_release_en3", rise_t[3], t + 25);
      req = '0;
      step(40);

      // Single request on domain 2 (leaves ptr at 3)
      t = cyc; req = 4'b0100;
      step(14);
      chk("single_en2_rise", rise_t[2], t + 1);
      chk("single_ack2_rise", arise_t[2], t + 3);
      chk("single_busy_fall", bfall_t, t + 9);

      // Round-robin from ptr=3 with domains 0 and 3 pending together
      t = cyc; req = 4'b1101;
      step(24);
      chk("rr_first_dom3", rise_t[3], t + 1);
      chk("rr_second_dom0", rise_t[0], t + 9);
      chk("rr_ack0", arise_t[0], t + 11);

      // One-cycle glitch on domain 1 (ptr is 1 here)
      t = cyc; req = 4'b1111;
      step(1);
      req = 4'b1101;
      step(16);
      chk("glitch_en1_rise", rise_t[1], t + 1);
      chk("glitch_ack1_rise", arise_t[1], t + 3);
      chk("glitch_en1_fall", fall_t[1], t + 9);
      chk("glitch_ack1_fall", afall_t[1], t + 11);

      // Reset one cycle after a grant on domain 0
      req = '0; rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(3);
      arise_t[0] = -1;
      t = cyc; req = 4'b0001;
      step(1);
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(2);
      chk("midreset_no_ack", arise_t[0], -1);
      step(4);
      chk("midreset_regrant", rise_t[0], t + 4);
      chk("midreset_ack", arise_t[0], t + 6);

      // Randomised requests with occasional resets
      for (int c = 0; c < 2500; c++) begin
         if ($urandom_range(0, 5) == 0) req[$urandom_range(0, N - 1)] ^= 1'b1;
         rst = ($urandom_range(0, 299) == 0);
         step(1);
      end
      rst = 1'b0;
      step(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
